dac_mix_sched: RTL and testbench



---
 rtl/dac_mix_sched.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dac_mix_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_mix_sched.sv
// Frame-synchronous DAC mixer: one time-multiplexed MAC pass over NSRC sources per lrck frame.
// Optional build macro SOFT_MUTE_EN: mute ramps the output down/up over 8 passes instead of hard zeroing.
module dac_mix_sched #(
  parameter int NSRC  = 4,
  parameter int VOL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lrck,
  input  logic [NSRC*16-1:0]    src_l,
  input  logic [NSRC*16-1:0]    src_r,
  input  logic [NSRC-1:0]       src_en,
  input  logic [NSRC*VOL_W-1:0] vol,
  input  logic                  mute,
  output logic [15:0]           out_l,
  output logic [15:0]           out_r,
  output logic                  frame_strobe,
  output logic [1:0]            clip,
  output logic                  busy,
  output logic                  overrun
);

  localparam int PROD_W = 16 + VOL_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NSRC);
  localparam int IDX_W  = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSRC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ACC     = 3'd2,
    ST_SAT     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic sync1_q, sync2_q, sync3_q;
  logic frame_ev_s;

  logic [NSRC*16-1:0]    snap_l_q, snap_l_d;
  logic [NSRC*16-1:0]    snap_r_q, snap_r_d;
  logic [NSRC-1:0]       snap_en_q, snap_en_d;
  logic [NSRC*VOL_W-1:0] snap_vol_q, snap_vol_d;
  logic                  mute_q, mute_d;

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;

  logic [15:0] out_l_q, out_l_d;
  logic [15:0] out_r_q, out_r_d;
  logic [1:0]  clip_q, clip_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic signed [15:0]       sel_l_s, sel_r_s;
  logic [VOL_W-1:0]         sel_vol_s;
  logic                     sel_en_s;
  logic signed [PROD_W-1:0] prod_l_s, prod_r_s;
  logic [16:0]              sat_l_s, sat_r_s;

`ifdef SOFT_MUTE_EN
  logic [3:0] ramp_q, ramp_d;
`endif

  // {clip, value}: arithmetic shift by 3 then clamp to the signed 16-bit range
  function automatic logic [16:0] sat16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> 3;
    if (s > ACC_W'(32'sd32767)) begin
      sat16 = {1'b1, 16'h7fff};
    end else if (s < ACC_W'(-32'sd32768)) begin
      sat16 = {1'b1, 16'h8000};
    end else begin
      sat16 = {1'b0, s[15:0]};
    end
  endfunction

`ifdef SOFT_MUTE_EN
  // v * r / 8, rounded toward negative infinity; r <= 8 keeps the result in range
  function automatic logic [15:0] ramp_scale(input logic [15:0] v, input logic [3:0] r);
    logic signed [20:0] p;
    p = 21'($signed(v)) * 21'($signed({1'b0, r}));
    ramp_scale = 16'(p >>> 3);
  endfunction
`endif

  assign frame_ev_s   = sync2_q & ~sync3_q;
  assign out_l        = out_l_q;
  assign out_r        = out_r_q;
  assign clip         = clip_q;
  assign frame_strobe = strobe_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

  // lrck synchronizer and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= lrck;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Source selected by idx and its scaled products for both channels
  always_comb begin
    sel_l_s   = 16'sd0;
    sel_r_s   = 16'sd0;
    sel_vol_s = '0;
    sel_en_s  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_l_s   = snap_l_q[16*i +: 16];
        sel_r_s   = snap_r_q[16*i +: 16];
        sel_vol_s = snap_vol_q[VOL_W*i +: VOL_W];
        sel_en_s  = snap_en_q[i];
      end else begin
        sel_en_s  = sel_en_s;
      end
    end
    prod_l_s = PROD_W'(sel_l_s) * PROD_W'($signed({1'b0, sel_vol_s}));
    prod_r_s = PROD_W'(sel_r_s) * PROD_W'($signed({1'b0, sel_vol_s}));
    sat_l_s  = sat16(acc_l_q);
    sat_r_s  = sat16(acc_r_q);
  end

  // Next-state and datapath updates for the mix pass
  always_comb begin
    state_d    = state_q;
    snap_l_d   = snap_l_q;
    snap_r_d   = snap_r_q;
    snap_en_d  = snap_en_q;
    snap_vol_d = snap_vol_q;
    mute_d     = mute_q;
    idx_d      = idx_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    out_l_d    = out_l_q;
    out_r_d    = out_r_q;
    clip_d     = clip_q;
    strobe_d   = 1'b0;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
`ifdef SOFT_MUTE_EN
    ramp_d     = ramp_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (frame_ev_s) begin
          state_d = ST_CAPTURE;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        snap_l_d   = src_l;
        snap_r_d   = src_r;
        snap_en_d  = src_en;
        snap_vol_d = vol;
        mute_d     = mute;
        acc_l_d    = '0;
        acc_r_d    = '0;
        idx_d      = '0;
        state_d    = ST_ACC;
        if (frame_ev_s) overrun_d = 1'b1;
        else            overrun_d = overrun_q;
      end
      ST_ACC: begin
        if (sel_en_s) begin
          acc_l_d = acc_l_q + ACC_W'(prod_l_s);
          acc_r_d = acc_r_q + ACC_W'(prod_r_s);
        end else begin
          acc_l_d = acc_l_q;
        end
        if (idx_q == IDX_LAST) begin
          state_d = ST_SAT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (frame_ev_s) overrun_d = 1'b1;
        else            overrun_d = overrun_q;
      end
      ST_SAT: begin
`ifdef SOFT_MUTE_EN
        if (mute_q) begin
          ramp_d = (ramp_q != 4'd0) ? ramp_q - 4'd1 : 4'd0;
        end else begin
          ramp_d = (ramp_q < 4'd8) ? ramp_q + 4'd1 : 4'd8;
        end
        out_l_d = ramp_scale(sat_l_s[15:0], ramp_d);
        out_r_d = ramp_scale(sat_r_s[15:0], ramp_d);
        clip_d  = {sat_r_s[16], sat_l_s[16]} & {2{ramp_d != 4'd0}};
`else
        if (mute_q) begin
          out_l_d = 16'd0;
          out_r_d = 16'd0;
          clip_d  = 2'b00;
        end else begin
          out_l_d = sat_l_s[15:0];
          out_r_d = sat_r_s[15:0];
          clip_d  = {sat_r_s[16], sat_l_s[16]};
        end
`endif
        strobe_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_DONE;
        if (frame_ev_s) overrun_d = 1'b1;
        else            overrun_d = overrun_q;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Snapshot, accumulator and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_l_q   <= '0;
      snap_r_q   <= '0;
      snap_en_q  <= '0;
      snap_vol_q <= '0;
      mute_q     <= 1'b0;
      idx_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      out_l_q    <= 16'd0;
      out_r_q    <= 16'd0;
      clip_q     <= 2'b00;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SOFT_MUTE_EN
      ramp_q     <= 4'd8;
`endif
    end else begin
      snap_l_q   <= snap_l_d;
      snap_r_q   <= snap_r_d;
      snap_en_q  <= snap_en_d;
      snap_vol_q <= snap_vol_d;
      mute_q     <= mute_d;
      idx_q      <= idx_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      clip_q     <= clip_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
`ifdef SOFT_MUTE_EN
      ramp_q     <= ramp_d;
`endif
    end
  end

endmodule

// File: tb/tb_dac_mix_sched.sv
// Randomized bench for dac_mix_sched against an integer-arithmetic mixing model.
module tb_dac_mix_sched;

  localparam int NSRC  = 4;
  localparam int VOL_W = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  lrck = 1'b0;
  logic [NSRC*16-1:0]    src_l = '0;
  logic [NSRC*16-1:0]    src_r = '0;
  logic [NSRC-1:0]       src_en = '0;
  logic [NSRC*VOL_W-1:0] vol = '0;
  logic                  mute = 1'b0;
  logic [15:0]           out_l, out_r;
  logic                  frame_strobe;
  logic [1:0]            clip;
  logic                  busy, overrun;

  int n_vec = 0;
  int n_err = 0;

  // Model state: per-source stimulus and expected results
  int  sl[NSRC], sr[NSRC], vv[NSRC];
  bit  ee[NSRC];
  bit  mt;
  int  ramp_m = 8;
  logic [15:0] exp_l, exp_r;
  logic [1:0]  exp_clip;

  dac_mix_sched #(.NSRC(NSRC), .VOL_W(VOL_W)) dut (
    .clk(clk), .reset(reset), .lrck(lrck),
    .src_l(src_l), .src_r(src_r), .src_en(src_en), .vol(vol), .mute(mute),
    .out_l(out_l), .out_r(out_r), .frame_strobe(frame_strobe), .clip(clip),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int clamp16(input int v, output bit c);
    c = 1'b0;
    if (v > 32767)  begin c = 1'b1; return 32767; end
    if (v < -32768) begin c = 1'b1; return -32768; end
    return v;
  endfunction

  // Expected result of one completed pass from the current stimulus arrays
  task automatic model_pass();
    int al, ar;
    bit cl, cr;
    al = 0; ar = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (ee[i]) begin
        al += sl[i] * vv[i];
        ar += sr[i] * vv[i];
      end
    end
    al = clamp16(al >>> 3, cl);
    ar = clamp16(ar >>> 3, cr);
`ifdef SOFT_MUTE_EN
    if (mt) ramp_m = (ramp_m > 0) ? ramp_m - 1 : 0;
    else    ramp_m = (ramp_m < 8) ? ramp_m + 1 : 8;
    al = (al * ramp_m) >>> 3;
    ar = (ar * ramp_m) >>> 3;
    if (ramp_m == 0) begin cl = 1'b0; cr = 1'b0; end
`else
    if (mt) begin al = 0; ar = 0; cl = 1'b0; cr = 1'b0; end
`endif
    exp_l    = 16'(al);
    exp_r    = 16'(ar);
    exp_clip = {cr, cl};
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NSRC; i++) begin
      src_l[16*i +: 16]       = 16'(sl[i]);
      src_r[16*i +: 16]       = 16'(sr[i]);
      vol[VOL_W*i +: VOL_W]   = VOL_W'(vv[i]);
      src_en[i]               = ee[i];
    end
    mute = mt;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NSRC; i++) begin
      sl[i] = 0; sr[i] = 0; vv[i] = 8; ee[i] = 1'b0;
    end
    mt = 1'b0;
  endtask

  task automatic randomize_srcs();
    for (int i = 0; i < NSRC; i++) begin
      sl[i] = int'($signed(16'($urandom)));
      sr[i] = int'($signed(16'($urandom)));
      vv[i] = int'($urandom_range(0, 15));
      ee[i] = ($urandom_range(0, 3) != 0);
    end
    mt = ($urandom_range(0, 7) == 0);
  endtask

  // One full frame: raise lrck, wait for the strobe and check everything it carries
  task automatic run_pass(input string tag);
    int  cyc;
    bit  seen;
    model_pass();
    apply_inputs();
    @(posedge clk); #1;
    lrck = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (frame_strobe) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(NSRC + 5));
    check({tag, "_out_l"}, {16'd0, out_l}, {16'd0, exp_l});
    check({tag, "_out_r"}, {16'd0, out_r}, {16'd0, exp_r});
    check({tag, "_clip"}, {30'd0, clip}, {30'd0, exp_clip});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    // Inputs changed after the strobe must not disturb the held outputs
    randomize_srcs();
    apply_inputs();
    @(posedge clk); #1;
    check({tag, "_strobe_w"}, {31'd0, frame_strobe}, 32'd0);
    lrck = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_hold_l"}, {16'd0, out_l}, {16'd0, exp_l});
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int strobes, first_cyc;
    logic [15:0] keep_l, keep_r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_l", {16'd0, out_l}, 32'd0);
    check("rst_out_r", {16'd0, out_r}, 32'd0);
    check("rst_clip", {30'd0, clip}, 32'd0);
    check("rst_strobe", {31'd0, frame_strobe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Single source unity gain
    clear_srcs();
    sl[0] = 1000; sr[0] = -1000; vv[0] = 8; ee[0] = 1'b1;
    run_pass("unity");

    // Positive and negative saturation
    clear_srcs();
    for (int i = 0; i < NSRC; i++) begin sl[i] = 20000; vv[i] = 15; ee[i] = 1'b1; end
    run_pass("sat_pos");
    for (int i = 0; i < NSRC; i++) sl[i] = -20000;
    run_pass("sat_neg");

    // Mixed gains with a negative sum
    clear_srcs();
    sl[0] = 100; vv[0] = 4; ee[0] = 1'b1;
    sl[1] = -50; vv[1] = 12; ee[1] = 1'b1;
    run_pass("mixgain");

    // Mute sequence on a constant 8000 mix, then unmute
    clear_srcs();
    sl[0] = 8000; sr[0] = -8000; vv[0] = 8; ee[0] = 1'b1;
    mt = 1'b1;
    for (int k = 0; k < 9; k++) run_pass("mute");
    mt = 1'b0;
    for (int k = 0; k < 9; k++) run_pass("unmute");

    // Randomized passes
    for (int k = 0; k < 40; k++) begin
      randomize_srcs();
      run_pass("rand");
    end

    // Second lrck edge 3 cycles after the first: ignored, flagged as overrun
    clear_srcs();
    sl[0] = 1234; sr[0] = -4321; vv[0] = 8; ee[0] = 1'b1;
    model_pass();
    keep_l = exp_l; keep_r = exp_r;
    apply_inputs();
    @(posedge clk); #1;
    lrck = 1'b1;
    @(posedge clk); #1;
    lrck = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    lrck = 1'b1;
    strobes = 0; first_cyc = 0;
    for (int c = 4; c <= 34; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        randomize_srcs();
        apply_inputs();
      end
      if (frame_strobe) begin
        strobes++;
        if (first_cyc == 0) first_cyc = c;
      end
    end
    check("ovr_strobes", 32'(strobes), 32'd1);
    check("ovr_latency", 32'(first_cyc), 32'(NSRC + 5));
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_out_l", {16'd0, out_l}, {16'd0, keep_l});
    check("ovr_out_r", {16'd0, out_r}, {16'd0, keep_r});
    lrck = 1'b0;
    repeat (4) @(posedge clk);

    // Reset in the middle of the accumulate phase
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    ramp_m = 8;
    repeat (3) @(posedge clk);
    clear_srcs();
    sl[0] = 3000; sr[0] = 3000; vv[0] = 8; ee[0] = 1'b1;
    run_pass("pre_abort");
    @(posedge clk); #1;
    lrck = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    lrck = 1'b0;
    @(posedge clk); #1;
    check("abort_out_l", {16'd0, out_l}, 32'd0);
    check("abort_out_r", {16'd0, out_r}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_strobe", {31'd0, frame_strobe}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ramp_m = 8;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (frame_strobe) strobes++;
    end
    check("abort_no_strobe", 32'(strobes), 32'd0);
    clear_srcs();
    sl[0] = 1000; sr[0] = -1000; vv[0] = 8; ee[0] = 1'b1;
    run_pass("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
